// File: rtl/lcd_fb_ahb_slave_if.sv
// ---------------------------------------------------------------------------
// lcd_fb_ahb_slave_if
//   AHB-lite signal bundle between the LCD DMA master and the frame-buffer
//   slave model.
//
//   Handshake: a transfer's address phase is accepted on the rising edge on
//   which HSEL = 1, HTRANS[1] = 1 (NONSEQ/SEQ) and the slave's HREADY = 1.
//   Its data phase occupies the following cycle(s); it ends on the first
//   rising edge with HREADY = 1. HRDATA/HRESP are valid in that final cycle,
//   and HWDATA must be held by the master until that edge.
//
//   Modports:
//     master : drives HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA,
//              observes HREADY/HRESP/HRDATA
//     slave  : the reverse
// ---------------------------------------------------------------------------
interface lcd_fb_ahb_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/lcd_fb_ahb_slave.sv
// ---------------------------------------------------------------------------
// lcd_fb_ahb_slave
//   AHB slave modelling the LCD frame-buffer memory. Serves single and
//   INCR-burst reads from the LCD DMA master and accepts word writes so the
//   frame can be preloaded. Every data phase is stretched by WAIT_STATES
//   HREADY-low cycles.
//
//   Optional feature (macro LCD_FB_SLAVE_ERR_EN): out-of-window, misaligned
//   or non-word transfers receive the two-cycle AHB ERROR response. Without
//   the macro every transfer is OKAY and the word index wraps modulo
//   DEPTH_WORDS.
//
//   Ports:
//     HCLK      : bus clock (posedge)
//     HRESET    : asynchronous active-low reset
//     ahb       : AHB slave modport (HSEL..HWDATA in, HREADY/HRESP/HRDATA out)
//     rd_beats  : count of completed OKAY reads, saturating at 16'hFFFF
//     dbg_state : current FSM state encoding (IDLE=0, WAIT=1, ERR1=2, ERR2=3)
// ---------------------------------------------------------------------------
module lcd_fb_ahb_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0200,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  lcd_fb_ahb_slave_if.slave    ahb,
  output logic [15:0]          rd_beats,
  output logic [1:0]           dbg_state
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam int         WS_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0] WS_LOAD   = 4'(WS_LOAD_I);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t          state_q,    state_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic            dp_valid_q, dp_valid_d;   // a legal data phase is pending
  logic            dp_write_q, dp_write_d;   // pending data phase is a write
  logic [AW-1:0]   dp_idx_q,   dp_idx_d;
  logic [15:0]     rd_beats_q, rd_beats_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            hready;
  logic [1:0]      hresp;
  logic [31:0]     hrdata;
  logic [31:0]     offset;
  logic [AW-1:0]   cap_idx;
  logic            capture;
  logic            addr_legal;
  logic            complete;
  logic            mem_we;
  logic            unused_sigs;

  // 32-bit unsigned offset; addresses below BASE_ADDR wrap to high indices.
  assign offset  = ahb.HADDR - BASE_ADDR;
  assign cap_idx = offset[AW+1:2];

`ifdef LCD_FB_SLAVE_ERR_EN
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  assign addr_legal = (ahb.HADDR >= BASE_ADDR)
                   && ({1'b0, ahb.HADDR} < END_ADDR)
                   && (ahb.HADDR[1:0] == 2'b00)
                   && (ahb.HSIZE == 3'b010);
`else
  assign addr_legal = 1'b1;
`endif

  assign unused_sigs = ^{ahb.HBURST, ahb.HSIZE, offset[31:AW+2], offset[1:0]};

  // A new address phase is only taken while this slave shows HREADY high.
  assign capture = hready && ahb.HSEL && ahb.HTRANS[1];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    rd_beats_d = rd_beats_q;
    hready     = 1'b1;
    hresp      = 2'b00;
    complete   = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        hready   = 1'b1;
        complete = dp_valid_q;
      end
      ST_WAIT: begin
        hready = 1'b0;
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
`ifdef LCD_FB_SLAVE_ERR_EN
      ST_ERR1: begin
        hready  = 1'b0;
        hresp   = 2'b01;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        hready  = 1'b1;
        hresp   = 2'b01;
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Retire the current data phase before looking at an overlapping
    // address phase, so a capture on the same edge re-arms the pipeline.
    if (complete) begin
      dp_valid_d = 1'b0;
      if (dp_write_q) begin
        mem_we = 1'b1;
      end else if (rd_beats_q != 16'hFFFF) begin
        rd_beats_d = rd_beats_q + 16'd1;
      end
    end

    if (capture) begin
      if (addr_legal) begin
        dp_valid_d = 1'b1;
        dp_write_d = ahb.HWRITE;
        dp_idx_d   = cap_idx;
        wait_cnt_d = WS_LOAD;
        state_d    = HAS_WAIT ? ST_WAIT : ST_IDLE;
      end
`ifdef LCD_FB_SLAVE_ERR_EN
      else begin
        dp_valid_d = 1'b0;
        dp_write_d = 1'b0;
        state_d    = ST_ERR1;
      end
`endif
    end
  end

  // Read data is driven only in the completing cycle of a read.
  always_comb begin
    hrdata = 32'h0;
    if (complete && !dp_write_q) begin
      hrdata = mem_q[dp_idx_q];
    end
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      rd_beats_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      rd_beats_q <= rd_beats_d;
    end
  end

  // Frame contents survive reset; a write only lands when its data phase
  // completes, so a reset mid-transfer drops it.
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      mem_q[dp_idx_q] <= ahb.HWDATA;
    end
  end

  assign ahb.HREADY = hready;
  assign ahb.HRDATA = hrdata;
`ifdef LCD_FB_SLAVE_ERR_EN
  assign ahb.HRESP  = hresp;
`else
  assign ahb.HRESP  = 2'b00;
`endif
  assign rd_beats   = rd_beats_q;
  assign dbg_state  = state_q;

endmodule
